// File: rtl/clave_hit_judge.sv
// Grades player button presses against the five son-clave beats of one measure
// and keeps score/combo; all outputs registered, one cycle after the judged tick.
module clave_hit_judge #(
   parameter logic [12:0] MAXCOUNT = 13'd6600,
   parameter logic [12:0] WINDOW   = 13'd100,
   parameter logic [12:0] PERFECT  = 13'd30,
   parameter logic [12:0] BEAT0    = 13'd400,
   parameter logic [12:0] BEAT1    = 13'd1600,
   parameter logic [12:0] BEAT2    = 13'd2800,
   parameter logic [12:0] BEAT3    = 13'd4400,
   parameter logic [12:0] BEAT4    = 13'd5200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic [12:0] count,
   input  logic        btn,
   output logic        hit_perfect,
   output logic        hit_good,
   output logic        miss,
   output logic [2:0]  beat_idx,
   output logic [15:0] score,
   output logic [7:0]  combo,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, ARMED, OPEN, DONE} state_t;

   state_t      state, state_nxt;
   logic        sync1, sync2, sync3, press;
   logic [12:0] beat, win_lo, win_hi, diff;
   logic        window_closed, perfect_zone;
   logic [16:0] score_sum;
   logic [15:0] score_sat;
   logic [7:0]  combo_sat;
   logic [2:0]  beat_nxt;
   logic [15:0] score_nxt;
   logic [7:0]  combo_nxt;
   logic        perfect_nxt, good_nxt, miss_nxt, advance;

   // Two-flop synchronizer, then a registered rising-edge detect: one press per push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         sync3 <= sync2;
         press <= sync2 & ~sync3;
      end
   end

   always_comb begin
      case (beat_idx)
         3'd0:    beat = BEAT0;
         3'd1:    beat = BEAT1;
         3'd2:    beat = BEAT2;
         3'd3:    beat = BEAT3;
         default: beat = BEAT4;
      endcase
   end

   assign win_lo        = beat - WINDOW;
   assign win_hi        = beat + WINDOW;
   assign diff          = (count >= beat) ? (count - beat) : (beat - count);
   assign perfect_zone  = (diff <= PERFECT);
   // MAXCOUNT closes the window even if the beat table were mis-set past the measure end.
   assign window_closed = (count > win_hi) || (count >= MAXCOUNT);

   assign score_sum = {1'b0, score} + {15'd0, perfect_zone ? 2'd2 : 2'd1};
   assign score_sat = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   assign combo_sat = (combo == 8'hFF) ? combo : combo + 8'd1;

   always_comb begin
      state_nxt   = state;
      beat_nxt    = beat_idx;
      score_nxt   = score;
      combo_nxt   = combo;
      perfect_nxt = 1'b0;
      good_nxt    = 1'b0;
      miss_nxt    = 1'b0;
      advance     = 1'b0;
      if (go) begin
         state_nxt = ARMED;
         beat_nxt  = 3'd0;
         score_nxt = 16'd0;
         combo_nxt = 8'd0;
      end else begin
         case (state)
            ARMED: if (count >= win_lo) state_nxt = OPEN;
            OPEN: begin
               // A closing window wins over a press landing on the same tick.
               if (window_closed) begin
                  miss_nxt  = 1'b1;
                  combo_nxt = 8'd0;
                  advance   = 1'b1;
               end else if (press) begin
                  perfect_nxt = perfect_zone;
                  good_nxt    = ~perfect_zone;
                  score_nxt   = score_sat;
                  combo_nxt   = combo_sat;
                  advance     = 1'b1;
               end
            end
            default: state_nxt = state;
         endcase
         if (advance) begin
            beat_nxt  = beat_idx + 3'd1;
            state_nxt = (beat_idx == 3'd4) ? DONE : ARMED;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         beat_idx    <= 3'd0;
         score       <= 16'd0;
         combo       <= 8'd0;
         hit_perfect <= 1'b0;
         hit_good    <= 1'b0;
         miss        <= 1'b0;
      end else begin
         state       <= state_nxt;
         beat_idx    <= beat_nxt;
         score       <= score_nxt;
         combo       <= combo_nxt;
         hit_perfect <= perfect_nxt;
         hit_good    <= good_nxt;
         miss        <= miss_nxt;
      end
   end

   assign done = (state == DONE);

endmodule

// File: tb/tb_clave_hit_judge.sv
// Scoreboard bench for clave_hit_judge: directed beat scenarios plus randomized measures.
module tb_clave_hit_judge;

   localparam int W = 100;
   localparam int P = 30;

   logic        clk = 1'b0;
   logic        reset, go, btn;
   logic [12:0] count;
   logic        hit_perfect, hit_good, miss, done;
   logic [2:0]  beat_idx;
   logic [15:0] score;
   logic [7:0]  combo;

   clave_hit_judge dut (
      .clk(clk), .reset(reset), .go(go), .count(count), .btn(btn),
      .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss),
      .beat_idx(beat_idx), .score(score), .combo(combo), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int tag;
      int kind;   // {perfect, good, miss}
      int score;
      int combo;
      int beat;
   } exp_t;

   exp_t q[$];
   int tests = 0, errors = 0;
   int edge_cnt = 0;
   int n_perf = 0, n_good = 0, n_miss = 0;

   // Reference model: mode 0 idle, 1 measure running, 2 finished.
   int m_mode, m_open, m_beat, m_score, m_combo;
   int b1, b2, b3, b4;
   int beats[5] = '{400, 1600, 2800, 4400, 5200};

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0; m_open = 0; m_beat = 0; m_score = 0; m_combo = 0;
      b1 = 0; b2 = 0; b3 = 0; b4 = 0;
   endtask

   task automatic advance_beat();
      m_beat++;
      m_open = 0;
      if (m_beat == 5) m_mode = 2;
   endtask

   task automatic step(input logic g, input int c, input logic b);
      int   press, bt, d;
      exp_t e;
      @(negedge clk);
      go = g; count = c[12:0]; btn = b;
      // A button rise is seen as a press three edges later.
      press = (b3 == 1 && b4 == 0) ? 1 : 0;
      b4 = b3; b3 = b2; b2 = b1; b1 = int'(b);
      if (g) begin
         m_mode = 1; m_open = 0; m_beat = 0; m_score = 0; m_combo = 0;
      end else if (m_mode == 1) begin
         bt = beats[m_beat];
         if (m_open == 0) begin
            if (c >= bt - W) m_open = 1;
         end else if (c > bt + W) begin
            m_combo = 0;
            advance_beat();
            e = '{tag: edge_cnt + 1, kind: 3'b001, score: m_score, combo: m_combo, beat: m_beat};
            q.push_back(e);
         end else if (press == 1) begin
            d = (c >= bt) ? c - bt : bt - c;
            m_score = (d <= P) ? m_score + 2 : m_score + 1;
            if (m_score > 65535) m_score = 65535;
            if (m_combo < 255) m_combo++;
            advance_beat();
            e = '{tag: edge_cnt + 1, kind: (d <= P) ? 3'b100 : 3'b010,
                  score: m_score, combo: m_combo, beat: m_beat};
            q.push_back(e);
         end
      end
   endtask

   task automatic sweep(input int from, input int to, input logic b);
      for (int c = from; c <= to; c++) step(1'b0, c, b);
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      edge_cnt++;
   end

   // Monitor: every output pulse must match the oldest outstanding expectation.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && (hit_perfect || hit_good || miss)) begin
            if (q.size() == 0) begin
               tests++; errors++;
               $display("FAIL sb_unexpected: pulses pgm=%b at edge %0d, none expected",
                        {hit_perfect, hit_good, miss}, edge_cnt);
            end else begin
               e = q.pop_front();
               chk("sb_kind",  int'({hit_perfect, hit_good, miss}), e.kind);
               chk("sb_cycle", edge_cnt, e.tag);
               chk("sb_score", int'(score), e.score);
               chk("sb_combo", int'(combo), e.combo);
               chk("sb_beat",  int'(beat_idx), e.beat);
            end
         end
         n_perf += int'(hit_perfect);
         n_good += int'(hit_good);
         n_miss += int'(miss);
      end
   end

   initial begin
      int h0, m0, c, s0;
      logic b;
      reset = 1'b1; go = 1'b0; btn = 1'b0; count = 13'd0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_perfect", int'(hit_perfect), 0);
      chk("rst_good",    int'(hit_good), 0);
      chk("rst_miss",    int'(miss), 0);
      chk("rst_beat",    int'(beat_idx), 0);
      chk("rst_score",   int'(score), 0);
      chk("rst_combo",   int'(combo), 0);
      chk("rst_done",    int'(done), 0);
      reset = 1'b0;

      // 1: press landing exactly on beat 0
      step(1'b1, 0, 1'b0);
      sweep(1, 396, 1'b0);
      sweep(397, 420, 1'b1);
      sweep(421, 430, 1'b0);
      settle();
      chk("t1_score", int'(score), 2);
      chk("t1_combo", int'(combo), 1);
      chk("t1_beat",  int'(beat_idx), 1);
      chk("t1_nperf", n_perf, 1);

      // 2: press at 1500 ignored while armed, press at 1670 is good
      h0 = n_good; m0 = n_miss;
      step(1'b1, 0, 1'b0);
      sweep(1, 1496, 1'b0);
      sweep(1497, 1510, 1'b1);
      sweep(1511, 1666, 1'b0);
      sweep(1667, 1680, 1'b1);
      sweep(1681, 1700, 1'b0);
      settle();
      chk("t2_score", int'(score), 1);
      chk("t2_combo", int'(combo), 1);
      chk("t2_beat",  int'(beat_idx), 2);
      chk("t2_ngood", n_good - h0, 1);
      chk("t2_nmiss", n_miss - m0, 1);

      // 3: full measure with no presses
      m0 = n_miss;
      step(1'b1, 0, 1'b0);
      sweep(1, 6600, 1'b0);
      repeat (3) step(1'b0, 6600, 1'b0);
      settle();
      chk("t3_nmiss", n_miss - m0, 5);
      chk("t3_done",  int'(done), 1);
      chk("t3_score", int'(score), 0);
      chk("t3_combo", int'(combo), 0);
      chk("t3_beat",  int'(beat_idx), 5);

      // 4: press on the tick the window closes
      h0 = n_perf + n_good; m0 = n_miss;
      step(1'b1, 0, 1'b0);
      sweep(1, 497, 1'b0);
      sweep(498, 501, 1'b1);
      sweep(502, 510, 1'b0);
      settle();
      chk("t4_nmiss", n_miss - m0, 1);
      chk("t4_nhit",  n_perf + n_good - h0, 0);
      chk("t4_combo", int'(combo), 0);
      chk("t4_beat",  int'(beat_idx), 1);

      // 5: held button gives one hit; go beats a simultaneous press
      h0 = n_perf + n_good;
      step(1'b1, 0, 1'b0);
      sweep(1, 349, 1'b0);
      sweep(350, 700, 1'b1);
      settle();
      chk("t5_nhit",  n_perf + n_good - h0, 1);
      chk("t5_score", int'(score), 1);
      chk("t5_beat",  int'(beat_idx), 1);
      sweep(701, 1556, 1'b0);
      sweep(1557, 1559, 1'b1);
      step(1'b1, 1560, 1'b1);
      repeat (3) step(1'b0, 0, 1'b1);
      step(1'b0, 0, 1'b0);
      settle();
      chk("t5_go_nhit",  n_perf + n_good - h0, 1);
      chk("t5_go_score", int'(score), 0);
      chk("t5_go_beat",  int'(beat_idx), 0);
      chk("t5_go_combo", int'(combo), 0);

      // 6: asynchronous reset while beat 1 window is open
      step(1'b1, 0, 1'b0);
      sweep(1, 396, 1'b0);
      sweep(397, 405, 1'b1);
      sweep(406, 1650, 1'b0);
      settle();
      chk("t6_pre_score", int'(score), 2);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("t6_rst_score", int'(score), 0);
      chk("t6_rst_combo", int'(combo), 0);
      chk("t6_rst_beat",  int'(beat_idx), 0);
      chk("t6_rst_pulse", int'({hit_perfect, hit_good, miss}), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      s0 = n_perf + n_good + n_miss;
      sweep(0, 396, 1'b0);
      sweep(397, 405, 1'b1);
      sweep(406, 600, 1'b0);
      settle();
      chk("t6_idle_pulses", n_perf + n_good + n_miss - s0, 0);
      chk("t6_idle_score",  int'(score), 0);
      chk("t6_idle_done",   int'(done), 0);
      step(1'b1, 0, 1'b0);
      sweep(1, 396, 1'b0);
      sweep(397, 402, 1'b1);
      sweep(403, 410, 1'b0);
      settle();
      chk("t6_go_score", int'(score), 2);

      // Randomized measures with pauses, jumps and occasional restarts
      for (int r = 0; r < 8; r++) begin
         b = 1'b0;
         c = 0;
         step(1'b1, 0, b);
         while (c < 6600) begin
            if ($urandom_range(0, 499) == 0) begin
               c = 0;
               step(1'b1, c, b);
            end else begin
               c = c + int'($urandom_range(0, 20));
               if (c > 6600) c = 6600;
               step(1'b0, c, b);
            end
            if ($urandom_range(0, 7) == 0) b = ~b;
         end
         repeat (6) step(1'b0, 6600, 1'b0);
         settle();
         chk("rnd_score", int'(score), m_score);
         chk("rnd_combo", int'(combo), m_combo);
         chk("rnd_beat",  int'(beat_idx), m_beat);
         chk("rnd_done",  int'(done), (m_mode == 2) ? 1 : 0);
      end

      repeat (4) step(1'b0, 6600, 1'b0);
      @(negedge clk);
      #1;
      chk("sb_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
